hams_bitonic_block_packer: RTL and testbench

Upstream input stage of the bitonic sorter. Accepts a scalar stream of DATA_WIDTH-bit keys with a valid/ready handshake and packs every NUM_ELEMENTS consecutive keys into one vector block. It pads a short final block with PAD_VALUE sentinels so the sorter always sees full blocks. It presents the block, tagged with a last flag and a pad count, on a valid/ready output for the bitonic sort input.

---
 rtl/hams_bitonic_block_packer.sv | 114 +++++++++++
 tb/tb_hams_bitonic_block_packer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hams_bitonic_block_packer.sv
// hams_bitonic_block_packer: packs a scalar key stream into NUM_ELEMENTS-lane
// blocks for the bitonic sorter, padding short final blocks with PAD_VALUE.
// Ports:
//   clk, rst                  clock and async active-high reset
//   in_data/in_vld/in_last    key stream in, in_rdy back-pressure
//   out_data/out_vld/out_rdy  packed block out (lane k at [k*DATA_WIDTH +: DATA_WIDTH])
//   out_last, out_pad_cnt     block carries final key / number of padded lanes
//   blk_cnt                   blocks accepted downstream, wrapping
module hams_bitonic_block_packer #(
    parameter int                    NUM_ELEMENTS = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = {DATA_WIDTH{1'b1}},
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_vld,
    input  logic                                 in_last,
    output logic                                 in_rdy,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   out_data,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic                                 out_last,
    output logic [$clog2(NUM_ELEMENTS+1)-1:0]    out_pad_cnt,
    output logic [CNT_WIDTH-1:0]                 blk_cnt
);

    localparam int IW = $clog2(NUM_ELEMENTS);
    localparam int PW = $clog2(NUM_ELEMENTS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_HOLD
    } state_t;

    state_t                            r_state;
    logic [IW-1:0]                     r_idx;
    logic [NUM_ELEMENTS*DATA_WIDTH-1:0] r_data;
    logic                              r_vld;
    logic                              r_last;
    logic [PW-1:0]                     r_pad_cnt;
    logic [CNT_WIDTH-1:0]              r_blk_cnt;
    logic                              w_accept;

    // Gated by rst so the source sees no ready while reset is held.
    assign in_rdy   = (r_state == S_FILL) && !rst;
    assign w_accept = in_vld && in_rdy;

    assign out_data    = r_data;
    assign out_vld     = r_vld;
    assign out_last    = r_last;
    assign out_pad_cnt = r_pad_cnt;
    assign blk_cnt     = r_blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FILL;
            r_idx     <= '0;
            r_data    <= '0;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_pad_cnt <= '0;
            r_blk_cnt <= '0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_data[r_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        // A full lane set wins over in_last: no pad cycle.
                        if (r_idx == LAST_IDX) begin
                            r_last    <= in_last;
                            r_pad_cnt <= '0;
                            r_vld     <= 1'b1;
                            r_state   <= S_HOLD;
                        end else if (in_last) begin
                            r_last  <= 1'b1;
                            r_state <= S_PAD;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_PAD: begin
                    // Fill every lane above the last written one.
                    for (int k = 0; k < NUM_ELEMENTS; k++) begin
                        if (k > int'(r_idx)) begin
                            r_data[k*DATA_WIDTH +: DATA_WIDTH] <= PAD_VALUE;
                        end
                    end
                    r_pad_cnt <= PW'(NUM_ELEMENTS - 1) - PW'(r_idx);
                    r_vld     <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_rdy) begin
                        r_blk_cnt <= r_blk_cnt + CNT_WIDTH'(1);
                        r_vld     <= 1'b0;
                        r_idx     <= '0;
                        r_last    <= 1'b0;
                        r_pad_cnt <= '0;
                        r_state   <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hams_bitonic_block_packer.sv
// tb_hams_bitonic_block_packer: directed and randomized checks of the packer
// against a queue-based block model.
module tb_hams_bitonic_block_packer;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam logic [DW-1:0] PADV = 32'hFFFF_FFFF;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_vld;
    logic            in_last;
    logic            in_rdy;
    logic [N*DW-1:0] out_data;
    logic            out_vld;
    logic            out_rdy;
    logic            out_last;
    logic [2:0]      out_pad_cnt;
    logic [CW-1:0]   blk_cnt;

    int total;
    int bad;
    int exp_blk;

    hams_bitonic_block_packer #(
        .NUM_ELEMENTS(N),
        .DATA_WIDTH  (DW),
        .PAD_VALUE   (PADV),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_last    (in_last),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_last   (out_last),
        .out_pad_cnt(out_pad_cnt),
        .blk_cnt    (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic l);
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl rdy=%b vld=%b last=%b want 0 0 0",
                     in_rdy, out_vld, out_last);
        end
        total++;
        if (out_pad_cnt !== 3'd0 || blk_cnt !== 2'd0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_dat pad=%0d blk=%0d data=%h want zeros",
                     out_pad_cnt, blk_cnt, out_data);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy got=%b want 1", in_rdy);
        end
        exp_blk = 0;
    endtask

    task automatic test_full_block();
        out_rdy = 1'b1;
        step(); drive(32'h10, 1'b0);
        step(); drive(32'h20, 1'b0);
        step(); drive(32'h30, 1'b0);
        step();
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL full_early got vld=%b want 0", out_vld);
        end
        drive(32'h40, 1'b1);
        step();
        in_vld = 1'b0; in_last = 1'b0;
        total++;
        if (out_vld !== 1'b1 || in_rdy !== 1'b0 ||
            out_data !== {32'h40, 32'h30, 32'h20, 32'h10} ||
            out_last !== 1'b1 || out_pad_cnt !== 3'd0) begin
            bad++;
            $display("FAIL full_blk vld=%b rdy=%b d=%h l=%b p=%0d want 1 0 40302010 1 0",
                     out_vld, in_rdy, out_data, out_last, out_pad_cnt);
        end
        exp_blk = (exp_blk + 1) % 4;
        step();
        total++;
        if (out_vld !== 1'b0 || blk_cnt !== CW'(exp_blk)) begin
            bad++;
            $display("FAIL full_cnt vld=%b blk=%0d want 0 %0d", out_vld, blk_cnt, exp_blk);
        end
    endtask

    task automatic test_padded();
        out_rdy = 1'b1;
        step(); drive(32'hA, 1'b0);
        step(); drive(32'hB, 1'b0);
        step(); drive(32'hC, 1'b1);
        step();
        in_vld = 1'b0; in_last = 1'b0;
        total++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
            bad++;
            $display("FAIL pad_cycle rdy=%b vld=%b want 0 0", in_rdy, out_vld);
        end
        step();
        total++;
        if (out_vld !== 1'b1 || out_data !== {PADV, 32'hC, 32'hB, 32'hA} ||
            out_last !== 1'b1 || out_pad_cnt !== 3'd1) begin
            bad++;
            $display("FAIL pad1_blk vld=%b d=%h l=%b p=%0d want pad_cnt 1",
                     out_vld, out_data, out_last, out_pad_cnt);
        end
        exp_blk = (exp_blk + 1) % 4;
        step();
        drive(32'h5, 1'b1);
        total++;
        if (blk_cnt !== CW'(exp_blk)) begin
            bad++;
            $display("FAIL pad1_cnt got=%0d want %0d", blk_cnt, exp_blk);
        end
        step();
        in_vld = 1'b0; in_last = 1'b0;
        total++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
            bad++;
            $display("FAIL pad3_cycle rdy=%b vld=%b want 0 0", in_rdy, out_vld);
        end
        step();
        total++;
        if (out_vld !== 1'b1 || out_data !== {PADV, PADV, PADV, 32'h5} ||
            out_last !== 1'b1 || out_pad_cnt !== 3'd3) begin
            bad++;
            $display("FAIL pad3_blk vld=%b d=%h l=%b p=%0d want pad_cnt 3",
                     out_vld, out_data, out_last, out_pad_cnt);
        end
        exp_blk = (exp_blk + 1) % 4;
        step();
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        step(); drive(32'h1, 1'b0);
        step(); drive(32'h2, 1'b0);
        step(); drive(32'h3, 1'b0);
        step(); drive(32'h4, 1'b0);
        step();
        drive(32'h99, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (in_rdy !== 1'b0 || out_vld !== 1'b1 ||
                out_data !== {32'h4, 32'h3, 32'h2, 32'h1} ||
                out_last !== 1'b0 || out_pad_cnt !== 3'd0) begin
                bad++;
                $display("FAIL bp_hold%0d rdy=%b vld=%b d=%h l=%b p=%0d",
                         i, in_rdy, out_vld, out_data, out_last, out_pad_cnt);
            end
        end
        out_rdy = 1'b1;
        exp_blk = (exp_blk + 1) % 4;
        step();
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || blk_cnt !== CW'(exp_blk)) begin
            bad++;
            $display("FAIL bp_release vld=%b rdy=%b blk=%0d want 0 1 %0d",
                     out_vld, in_rdy, blk_cnt, exp_blk);
        end
        step(); drive(32'h9A, 1'b0);
        step(); drive(32'h9B, 1'b0);
        step(); drive(32'h9C, 1'b1);
        step();
        in_vld = 1'b0; in_last = 1'b0;
        total++;
        if (out_vld !== 1'b1 || out_last !== 1'b1 ||
            out_data !== {32'h9C, 32'h9B, 32'h9A, 32'h99}) begin
            bad++;
            $display("FAIL bp_next vld=%b l=%b d=%h want 9c9b9a99",
                     out_vld, out_last, out_data);
        end
        exp_blk = (exp_blk + 1) % 4;
        step();
    endtask

    task automatic test_stream_gaps();
        logic [DW-1:0]   kq[$];
        logic            lq[$];
        logic [N*DW-1:0] eb_d[$];
        logic            eb_l[$];
        int              eb_p[$];
        logic [DW-1:0]   cur[$];
        logic [N*DW-1:0] blk;
        int              len;
        int              nblk;
        int              cyc;
        for (int s = 0; s < 6; s++) begin
            len = (s == 0) ? 9 : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                kq.push_back($urandom);
                lq.push_back(i == len - 1);
            end
            // Model: chunk keys into groups of N, pad the short tail.
            for (int i = 0; i < len; i++) begin
                cur.push_back(kq[i]);
                if (cur.size() == N || lq[i]) begin
                    blk = '0;
                    for (int j = 0; j < N; j++)
                        blk[j*DW +: DW] = (j < cur.size()) ? cur[j] : PADV;
                    eb_d.push_back(blk);
                    eb_l.push_back(lq[i]);
                    eb_p.push_back(N - cur.size());
                    cur.delete();
                end
            end
            nblk = 0;
            cyc  = 0;
            while ((kq.size() > 0 || eb_d.size() > 0) && cyc < 2000) begin
                step();
                cyc++;
                if (kq.size() > 0 && $urandom_range(0, 2) != 0) begin
                    drive(kq[0], lq[0]);
                end else begin
                    in_vld  = 1'b0;
                    in_data = $urandom;
                    in_last = 1'($urandom_range(0, 1));
                end
                out_rdy = ($urandom_range(0, 3) != 0);
                #1;
                total++;
                if (blk_cnt !== CW'(exp_blk) || (out_vld && in_rdy)) begin
                    bad++;
                    $display("FAIL st_cyc blk=%0d want %0d vld=%b rdy=%b",
                             blk_cnt, exp_blk, out_vld, in_rdy);
                end
                if (in_vld && in_rdy) begin
                    void'(kq.pop_front());
                    void'(lq.pop_front());
                end
                if (out_vld && out_rdy) begin
                    total++;
                    if (eb_d.size() == 0) begin
                        bad++;
                        $display("FAIL st_extra unexpected block d=%h", out_data);
                    end else begin
                        if (out_data !== eb_d[0] || out_last !== eb_l[0] ||
                            out_pad_cnt !== 3'(eb_p[0])) begin
                            bad++;
                            $display("FAIL st_blk d=%h l=%b p=%0d want d=%h l=%b p=%0d",
                                     out_data, out_last, out_pad_cnt,
                                     eb_d[0], eb_l[0], eb_p[0]);
                        end
                        void'(eb_d.pop_front());
                        void'(eb_l.pop_front());
                        void'(eb_p.pop_front());
                    end
                    nblk++;
                    exp_blk = (exp_blk + 1) % 4;
                end
            end
            in_vld = 1'b0;
            in_last = 1'b0;
            total++;
            if (cyc >= 2000 || nblk != (len + N - 1) / N) begin
                bad++;
                $display("FAIL st_set%0d blocks=%0d want %0d cyc=%0d",
                         s, nblk, (len + N - 1) / N, cyc);
                kq.delete(); lq.delete();
                eb_d.delete(); eb_l.delete(); eb_p.delete();
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        step(); drive(32'h11, 1'b0);
        step(); drive(32'h22, 1'b0);
        step();
        in_vld = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b0 || blk_cnt !== 2'd0 ||
            out_data !== '0 || out_pad_cnt !== 3'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_fill vld=%b rdy=%b blk=%0d d=%h",
                     out_vld, in_rdy, blk_cnt, out_data);
        end
        exp_blk = 0;
        step();
        rst = 1'b0;
        drive(32'h31, 1'b0);
        step(); drive(32'h32, 1'b0);
        step(); drive(32'h33, 1'b0);
        step(); drive(32'h34, 1'b1);
        step();
        in_vld = 1'b0; in_last = 1'b0;
        total++;
        if (out_vld !== 1'b1 || out_last !== 1'b1 ||
            out_data !== {32'h34, 32'h33, 32'h32, 32'h31}) begin
            bad++;
            $display("FAIL rst_fresh vld=%b l=%b d=%h want 34333231",
                     out_vld, out_last, out_data);
        end
        exp_blk = (exp_blk + 1) % 4;
        step();
        out_rdy = 1'b0;
        step(); drive(32'h41, 1'b0);
        step(); drive(32'h42, 1'b0);
        step(); drive(32'h43, 1'b0);
        step(); drive(32'h44, 1'b0);
        step();
        in_vld = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (out_vld !== 1'b0 || blk_cnt !== 2'd0) begin
            bad++;
            $display("FAIL rst_hold vld=%b blk=%0d want 0 0", out_vld, blk_cnt);
        end
        exp_blk = 0;
        step();
        rst = 1'b0;
        step();
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rst_after vld=%b rdy=%b want 0 1", out_vld, in_rdy);
        end
    endtask

    task automatic test_counter_wrap();
        int seq[5] = '{1, 2, 3, 0, 1};
        out_rdy = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < N; i++) begin
                step();
                drive(32'($urandom), i == N - 1);
            end
            step();
            in_vld = 1'b0; in_last = 1'b0;
            step();
            total++;
            if (blk_cnt !== CW'(seq[b])) begin
                bad++;
                $display("FAIL wrap%0d got=%0d want %0d", b, blk_cnt, seq[b]);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_blk = 0;
        rst     = 1'b0;
        in_data = '0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        test_reset();
        test_full_block();
        test_padded();
        test_backpressure();
        test_stream_gaps();
        test_reset_mid();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
